// File: rtl/pwm_multi.sv
// Multi-channel PWM generator sharing one programmable-period counter.
// Supports edge-aligned and center-aligned modes, and double-buffers the period, mode and duty values.
module pwm_multi #(
    parameter int BITS     = 8,
    parameter int CHANNELS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     load,
    input  logic                     mode_in,
    input  logic [BITS-1:0]          period,
    input  logic [CHANNELS*BITS-1:0] dty,
    output logic [CHANNELS-1:0]      pwm,
    output logic                     period_end,
    output logic                     load_pending
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [BITS-1:0] ONE = BITS'(1);

    logic [BITS-1:0]          r_cnt;
    dir_t                     r_dir;
    logic [CHANNELS-1:0]      r_pwm;
    logic                     r_period_end;

    logic                     r_mode_act;
    logic [BITS-1:0]          r_per_act;
    logic [CHANNELS*BITS-1:0] r_duty_act;
    logic                     r_mode_stg;
    logic [BITS-1:0]          r_per_stg;
    logic [CHANNELS*BITS-1:0] r_duty_stg;
    logic                     r_pending;

    logic                     w_boundary;
    logic                     w_transfer;
    logic [BITS-1:0]          w_cnt_nxt;
    dir_t                     w_dir_nxt;
    logic [CHANNELS-1:0]      w_pwm_nxt;

    // Last cycle of the current period; center mode with P<=1 degenerates to a 1-cycle period
    always_comb begin
        w_boundary = 1'b0;
        if (r_mode_act) begin
            if (r_per_act <= ONE) begin
                w_boundary = 1'b1;
            end else begin
                w_boundary = (r_cnt == '0) && (r_dir == DIR_DOWN);
            end
        end else begin
            w_boundary = (r_cnt >= r_per_act);
        end
    end

    assign w_transfer = r_pending && !load && (!en || w_boundary);

    // Counter sequencing: the top value repeats once in center mode as the direction flips
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_dir_nxt = r_dir;
        if (!en || w_boundary) begin
            w_cnt_nxt = '0;
            w_dir_nxt = DIR_UP;
        end else if (!r_mode_act) begin
            w_cnt_nxt = r_cnt + ONE;
        end else if (r_dir == DIR_UP) begin
            if (r_cnt >= (r_per_act - ONE)) begin
                w_dir_nxt = DIR_DOWN;
            end else begin
                w_cnt_nxt = r_cnt + ONE;
            end
        end else begin
            w_cnt_nxt = r_cnt - ONE;
        end
    end

    // Per-channel unsigned compare against the active duty
    always_comb begin
        w_pwm_nxt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_pwm_nxt[i] = en && (r_cnt < r_duty_act[i*BITS +: BITS]);
        end
    end

    // Counter, direction and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_dir        <= DIR_UP;
            r_pwm        <= '0;
            r_period_end <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_dir        <= w_dir_nxt;
            r_pwm        <= w_pwm_nxt;
            r_period_end <= en && w_boundary;
        end
    end

    // Staging capture and staging-to-active transfer; a load always wins over a transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode_stg <= 1'b0;
            r_per_stg  <= '0;
            r_duty_stg <= '0;
            r_mode_act <= 1'b0;
            r_per_act  <= '0;
            r_duty_act <= '0;
            r_pending  <= 1'b0;
        end else if (load) begin
            r_mode_stg <= mode_in;
            r_per_stg  <= period;
            r_duty_stg <= dty;
            r_pending  <= 1'b1;
        end else if (w_transfer) begin
            r_mode_act <= r_mode_stg;
            r_per_act  <= r_per_stg;
            r_duty_act <= r_duty_stg;
            r_pending  <= 1'b0;
        end
    end

    assign pwm          = r_pwm;
    assign period_end   = r_period_end;
    assign load_pending = r_pending;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: a phase-index reference model checked every cycle,
// plus hand-computed waveform expectations for each scenario.
module tb_pwm_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic        mode_in;
    logic [7:0]  period;
    logic [31:0] dty;
    logic [3:0]  pwm;
    logic        period_end;
    logic        load_pending;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    pwm_multi #(.BITS(8), .CHANNELS(4)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .mode_in(mode_in),
        .period(period), .dty(dty), .pwm(pwm), .period_end(period_end),
        .load_pending(load_pending)
    );

    always #5 clk = ~clk;

    // Reference model: position k within the period and the period length derived from the mode
    bit       m_mode, s_mode, m_pend, m_pe;
    int       m_P, s_P, m_k;
    int       m_duty [4];
    int       s_duty [4];
    bit [3:0] m_pwm;

    function automatic int mlen(input bit md, input int p);
        if (!md) return p + 1;
        if (p <= 1) return 1;
        return 2 * p;
    endfunction

    function automatic int mcnt(input bit md, input int p, input int k);
        if (!md) return k;
        if (p <= 1) return 0;
        return (k < p) ? k : (2 * p - 1 - k);
    endfunction

    function automatic bit [3:0] mcmp();
        bit [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = (mcnt(m_mode, m_P, m_k) < m_duty[i]);
        return v;
    endfunction

    function automatic bit mbnd();
        return m_k == mlen(m_mode, m_P) - 1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= 1'b0; s_mode <= 1'b0; m_P <= 0; s_P <= 0; m_k <= 0;
            m_pend <= 1'b0; m_pe <= 1'b0; m_pwm <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                m_duty[i] <= 0;
                s_duty[i] <= 0;
            end
        end else begin
            m_pwm <= en ? mcmp() : 4'b0000;
            m_pe  <= en && mbnd();
            m_k   <= (!en || mbnd()) ? 0 : m_k + 1;
            if (load) begin
                s_mode <= mode_in;
                s_P    <= int'(period);
                for (int i = 0; i < 4; i++) s_duty[i] <= int'(dty[i*8 +: 8]);
                m_pend <= 1'b1;
            end else if (m_pend && (!en || mbnd())) begin
                m_mode <= s_mode;
                m_P    <= s_P;
                for (int i = 0; i < 4; i++) m_duty[i] <= s_duty[i];
                m_pend <= 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_pwm", 32'(pwm), 32'(m_pwm));
            chk("model_period_end", 32'(period_end), 32'(m_pe));
            chk("model_load_pending", 32'(load_pending), 32'(m_pend));
        end
    end

    // Load a configuration while disabled so it transfers at once, then enable
    task automatic cfg(input logic md, input logic [7:0] p, input logic [31:0] d);
        @(negedge clk);
        en = 1'b0; load = 1'b1; mode_in = md; period = p; dty = d;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        en = 1'b1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; mode_in = 1'b0; period = 8'd0; dty = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);
        chk("reset_pwm", 32'(pwm), 32'd0);
        chk("reset_period_end", 32'(period_end), 32'd0);
        chk("reset_load_pending", 32'(load_pending), 32'd0);

        // Edge mode, P=9, duties 0/3/10/255
        cfg(1'b0, 8'd9, 32'hFF_0A_03_00);
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            chk("t1_pwm0", 32'(pwm[0]), 32'd0);
            chk("t1_pwm1", 32'(pwm[1]), 32'((j % 10) < 3));
            chk("t1_pwm23", 32'(pwm[3:2]), 32'd3);
            chk("t1_period_end", 32'(period_end), 32'((j % 10) == 9));
        end

        // Center mode, P=8, ch0 duty 2
        cfg(1'b1, 8'd8, 32'h05_00_08_02);
        for (int j = 0; j < 32; j++) begin
            @(negedge clk);
            chk("t2_pwm0", 32'(pwm[0]), 32'(((j % 16) < 2) || ((j % 16) >= 14)));
            chk("t2_pwm1", 32'(pwm[1]), 32'd1);
            chk("t2_period_end", 32'(period_end), 32'((j % 16) == 15));
        end

        // Mid-period load of a new duty
        cfg(1'b0, 8'd9, 32'h00_00_00_03);
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            chk("t3_pwm0", 32'(pwm[0]), (j < 10) ? 32'(j < 3) : 32'((j - 10) < 7));
            chk("t3_load_pending", 32'(load_pending), 32'((j >= 5) && (j <= 8)));
            chk("t3_period_end", 32'(period_end), 32'((j % 10) == 9));
            load = (j == 4);
            dty  = 32'h00_00_00_07;
        end

        // Load on a boundary, disable/re-enable with new period, then async reset
        cfg(1'b0, 8'd9, 32'h00_00_00_03);
        for (int j = 0; j <= 50; j++) begin
            @(negedge clk);
            if (j < 20) chk("t4_pwm0", 32'(pwm[0]), 32'((j % 10) < 3));
            else if (j < 35) chk("t4_pwm0_new", 32'(pwm[0]), 32'((j % 10) < 7));
            if (j < 20) chk("t4_load_pending", 32'(load_pending), 32'((j >= 9) && (j <= 18)));
            if (j < 35) chk("t4_period_end", 32'(period_end), 32'((j % 10) == 9));
            if ((j >= 35) && (j <= 39)) begin
                chk("t5_off_pwm", 32'(pwm), 32'd0);
                chk("t5_off_period_end", 32'(period_end), 32'd0);
            end
            if (j == 37) chk("t5_pending_set", 32'(load_pending), 32'd1);
            if (j == 38) chk("t5_pending_clear", 32'(load_pending), 32'd0);
            if (j >= 40) begin
                chk("t5_pwm0", 32'(pwm[0]), 32'(((j - 40) % 5) < 2));
                chk("t5_period_end", 32'(period_end), 32'(((j - 40) % 5) == 4));
            end
            if (j == 50) chk("t6_pre_pending", 32'(load_pending), 32'd1);
            case (j)
                8:  begin load = 1'b1; dty = 32'h00_00_00_07; end
                34: en = 1'b0;
                36: begin load = 1'b1; period = 8'd4; dty = 32'h00_00_00_02; end
                39: en = 1'b1;
                49: begin load = 1'b1; period = 8'd3; dty = 32'h00_00_00_01; end
                default: load = 1'b0;
            endcase
        end

        #2 rst = 1'b1;
        #1;
        chk("t6_async_pwm", 32'(pwm), 32'd0);
        chk("t6_async_period_end", 32'(period_end), 32'd0);
        chk("t6_async_load_pending", 32'(load_pending), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            chk("t6_post_pwm", 32'(pwm), 32'd0);
            chk("t6_post_load_pending", 32'(load_pending), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
